// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter between NUM_REQ byte requesters
//
// Parameters:
//   NUM_REQ        number of requesters (2..8)
//   START_TIMEOUT  cycles to wait for tx_active to rise after a launch before aborting
//
// Optional feature macro: UART_TX_ARB_LOCK_EN
//   Adds input req_lock. A requester whose req_lock bit is set when its byte
//   completes keeps exclusive access until it drops req_lock in an idle cycle.
//   A launch timeout always drops the lock.
//
// Ports:
//   clk          system clock
//   sync_reset   synchronous active-high reset
//   req_valid    per-requester byte pending
//   req_data     byte of requester i at bits [8i+7:8i]
//   req_lock     (UART_TX_ARB_LOCK_EN only) per-requester lock request
//   req_ready    per-requester accept strobe (valid & ready)
//   req_done     one-cycle pulse when requester's byte has been shifted out
//   start_TX     launch pulse to the transmitter
//   SBUF_out     byte to the transmitter's SBUF_in
//   tx_active    transmitter busy flag
//   grant_id     index of the current or last granted requester
//   busy         arbiter not idle
//   timeout_err  one-cycle pulse when tx_active never rose after a launch
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 2,
    parameter int START_TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       sync_reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
`ifdef UART_TX_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]         req_lock,
`endif
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_REQ-1:0]         req_done,
    output logic                       start_TX,
    output logic [7:0]                 SBUF_out,
    input  logic                       tx_active,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       timeout_err
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int TW = (START_TIMEOUT > 0) ? $clog2(START_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMAX = TW'(START_TIMEOUT);

    typedef enum logic [3:0] {
        S_IDLE        = 4'b0001,
        S_LAUNCH      = 4'b0010,
        S_WAIT_ACTIVE = 4'b0100,
        S_WAIT_DONE   = 4'b1000
    } state_t;

    state_t              state, state_nxt;
    logic [GW-1:0]       last_grant;
    logic [GW-1:0]       grant_idx;
    logic                grant_found;
    logic                grant;
    logic [GW:0]         cand;
    logic [NUM_REQ-1:0]  eligible;
    logic [TW-1:0]       timer;

`ifdef UART_TX_ARB_LOCK_EN
    logic locked;
    logic lock_hold;

    // The lock only holds while the owner keeps req_lock high, so a release
    // takes effect in the same idle cycle it is seen.
    assign lock_hold = locked & req_lock[grant_id];
    assign eligible  = lock_hold ? (req_valid & (NUM_REQ'(1) << grant_id)) : req_valid;

    always_ff @(posedge clk) begin
        if (sync_reset)
            locked <= 1'b0;
        else if (timeout_err)
            locked <= 1'b0;
        else if (|req_done)
            locked <= req_lock[grant_id];
        else if (state == S_IDLE && !req_lock[grant_id])
            locked <= 1'b0;
    end
`else
    assign eligible = req_valid;
`endif

    // Round-robin search starting one past the last winner, wrapping modulo NUM_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, last_grant} + (GW+1)'(k);
            if (cand >= (GW+1)'(NUM_REQ))
                cand = cand - (GW+1)'(NUM_REQ);
            if (!grant_found && eligible[cand[GW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[GW-1:0];
            end
        end
    end

    assign grant = (state == S_IDLE) && !tx_active && grant_found;
    assign busy  = (state != S_IDLE);

    always_comb begin
        state_nxt   = state;
        req_ready   = '0;
        req_done    = '0;
        start_TX    = 1'b0;
        timeout_err = 1'b0;
        case (state)
            S_IDLE: begin
                if (grant) begin
                    req_ready[grant_idx] = 1'b1;
                    state_nxt            = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                start_TX  = 1'b1;
                state_nxt = S_WAIT_ACTIVE;
            end
            S_WAIT_ACTIVE: begin
                if (tx_active)
                    state_nxt = S_WAIT_DONE;
                else if (timer == TMAX) begin
                    timeout_err = 1'b1;
                    state_nxt   = S_IDLE;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_active) begin
                    req_done[grant_id] = 1'b1;
                    state_nxt          = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state      <= S_IDLE;
            SBUF_out   <= '0;
            grant_id   <= '0;
            last_grant <= GW'(NUM_REQ - 1);
            timer      <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                SBUF_out   <= req_data[{grant_idx, 3'b000} +: 8];
                grant_id   <= grant_idx;
                last_grant <= grant_idx;
            end
            // Timer saturates at TMAX rather than wrapping.
            if (state == S_LAUNCH)
                timer <= '0;
            else if (state == S_WAIT_ACTIVE && !tx_active && timer != TMAX)
                timer <= timer + 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and randomized checks of uart_tx_arbiter against a transaction-level model
module tb_uart_tx_arbiter;

    localparam int N  = 3;
    localparam int ST = 20;
    localparam int GW = $clog2(N);

    logic           clk = 1'b0;
    logic           sync_reset = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_ready, req_done;
    logic           start_TX;
    logic [7:0]     SBUF_out;
    logic           tx_active;
    logic [GW-1:0]  grant_id;
    logic           busy, timeout_err;
`ifdef UART_TX_ARB_LOCK_EN
    logic [N-1:0]   req_lock = '0;
`endif

    uart_tx_arbiter #(.NUM_REQ(N), .START_TIMEOUT(ST)) dut (
        .clk(clk),
        .sync_reset(sync_reset),
        .req_valid(req_valid),
        .req_data(req_data),
`ifdef UART_TX_ARB_LOCK_EN
        .req_lock(req_lock),
`endif
        .req_ready(req_ready),
        .req_done(req_done),
        .start_TX(start_TX),
        .SBUF_out(SBUF_out),
        .tx_active(tx_active),
        .grant_id(grant_id),
        .busy(busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] oh(input int i);
        return 32'(1) << i;
    endfunction

    // Behavioural transmitter: busy for 'frame' cycles after an accepted launch.
    logic       tx_en = 1'b1;
    logic       force_busy = 1'b0;
    int         frame = 4;
    logic [7:0] tx_cnt = '0;
    logic [7:0] tx_byte = '0;

    assign tx_active = force_busy | (tx_cnt != 0);

    always @(posedge clk) begin
        if (sync_reset)
            tx_cnt <= '0;
        else if (tx_cnt != 0)
            tx_cnt <= tx_cnt - 1'b1;
        else if (start_TX && tx_en) begin
            tx_cnt  <= 8'(frame);
            tx_byte <= SBUF_out;
        end
    end

    // Transaction-level reference: one byte in flight at a time, winner is the
    // first valid requester after the previous winner, launch one cycle after
    // acceptance, completion when the transmitter falls, abort after ST+1 idle cycles.
    logic       mon_en = 1'b1;
    int         m_last = N - 1, m_id = 0, m_wait = 0, mg = 0;
    logic       m_busy = 1'b0, m_due = 1'b0, m_launched = 1'b0, m_seen = 1'b0;
    logic       mf, b0, exp_done, exp_to, exp_grant;
    logic [7:0] m_byte = '0;
    int         acc_cnt [N] = '{default: 0};
    int         done_cnt [N] = '{default: 0};
    int         to_cnt [N] = '{default: 0};

    always @(negedge clk) begin
        if (sync_reset) begin
            m_last     = N - 1;
            m_busy     = 1'b0;
            m_due      = 1'b0;
            m_launched = 1'b0;
            m_seen     = 1'b0;
        end else if (mon_en) begin
            b0 = m_busy;
            check("busy", 32'(busy), 32'(m_busy));
            exp_done = 1'b0;
            exp_to   = 1'b0;
            if (m_due) begin
                check("start_tx", 32'(start_TX), 32'd1);
                check("sbuf_at_launch", 32'(SBUF_out), 32'(m_byte));
                check("grant_id", 32'(grant_id), 32'(m_id));
                m_due      = 1'b0;
                m_launched = 1'b1;
                m_wait     = 0;
                m_seen     = 1'b0;
            end else begin
                if (start_TX)
                    check("start_tx_spurious", 32'(start_TX), 32'd0);
                if (m_launched) begin
                    m_wait++;
                    exp_done = m_seen && !tx_active;
                    exp_to   = !m_seen && !tx_active && (m_wait == ST + 1);
                    if (tx_active)
                        m_seen = 1'b1;
                end
            end
            if (req_done != 0 || exp_done)
                check("req_done", 32'(req_done), exp_done ? oh(m_id) : 32'd0);
            if (timeout_err || exp_to)
                check("timeout_err", 32'(timeout_err), 32'(exp_to));
            if (exp_done) begin
                check("tx_byte", 32'(tx_byte), 32'(m_byte));
                check("sbuf_hold", 32'(SBUF_out), 32'(m_byte));
                done_cnt[m_id]++;
            end
            if (exp_to)
                to_cnt[m_id]++;
            if (exp_done || exp_to) begin
                m_busy     = 1'b0;
                m_launched = 1'b0;
            end
            mf = 1'b0;
            mg = 0;
            for (int d = 1; d <= N; d++)
                if (!mf && req_valid[(m_last + d) % N]) begin
                    mf = 1'b1;
                    mg = (m_last + d) % N;
                end
            exp_grant = !b0 && !tx_active && mf;
            if (req_ready != 0 || exp_grant)
                check("req_ready", 32'(req_ready), exp_grant ? oh(mg) : 32'd0);
            if (exp_grant) begin
                m_busy = 1'b1;
                m_due  = 1'b1;
                m_byte = req_data[8*mg +: 8];
                m_id   = mg;
                m_last = mg;
                acc_cnt[mg]++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        sync_reset = 1'b1;
        req_valid  = '0;
        force_busy = 1'b0;
        tx_en      = 1'b1;
        step();
        step();
        sync_reset = 1'b0;
    endtask

    task automatic wait_ready(input int lim, output logic [N-1:0] r);
        r = '0;
        for (int c = 0; c < lim; c++) begin
            @(negedge clk);
            if (req_ready != 0) begin
                r = req_ready;
                break;
            end
        end
    endtask

    task automatic wait_done(input int lim, output logic [N-1:0] d);
        d = '0;
        for (int c = 0; c < lim; c++) begin
            @(negedge clk);
            if (req_done != 0) begin
                d = req_done;
                break;
            end
        end
    endtask

    task automatic wait_idle(input string tag);
        logic ok;
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, 32'(ok), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_start"}, 32'(start_TX), 32'd0);
        check({tag, "_sbuf"}, 32'(SBUF_out), 32'd0);
        check({tag, "_grant_id"}, 32'(grant_id), 32'd0);
        check({tag, "_timeout"}, 32'(timeout_err), 32'd0);
        check({tag, "_done"}, 32'(req_done), 32'd0);
    endtask

    logic [N-1:0] r, d;
    int           cnt;
    int           total;

    initial begin
        do_reset();
        @(negedge clk);
        check_reset_outputs("rst");
        check("rst_ready", 32'(req_ready), 32'd0);

        // Single request with a 40-cycle frame (bit period 4).
        do_reset();
        frame = 40;
        req_data[7:0] = 8'h55;
        req_valid = 3'b001;
        wait_ready(10, r);
        check("t1_ready", 32'(r), 32'd1);
        step();
        req_valid = '0;
        wait_done(100, d);
        check("t1_done", 32'(d), 32'd1);
        @(negedge clk);
        check("t1_idle", 32'(busy), 32'd0);

        // Two requesters contending continuously.
        do_reset();
        frame = 4;
        req_data[7:0]  = 8'hA0;
        req_data[15:8] = 8'hB1;
        req_valid = 3'b011;
        for (int k = 0; k < 4; k++) begin
            wait_ready(60, r);
            check("t2_grant", 32'(r), (k % 2 == 0) ? 32'd1 : 32'd2);
        end
        step();
        req_valid = '0;
        wait_idle("t2_idle");

        // Transmitter busy from elsewhere blocks arbitration.
        do_reset();
        force_busy = 1'b1;
        req_data[15:8] = 8'h77;
        req_valid = 3'b010;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t3_hold", 32'(req_ready), 32'd0);
        end
        step();
        force_busy = 1'b0;
        @(negedge clk);
        check("t3_grant", 32'(req_ready), 32'd2);
        step();
        req_valid = '0;
        wait_idle("t3_idle");

        // Launch timeout: transmitter never responds.
        do_reset();
        tx_en = 1'b0;
        req_data[7:0] = 8'h3C;
        req_valid = 3'b001;
        wait_ready(10, r);
        check("t4_ready", 32'(r), 32'd1);
        step();
        req_valid = '0;
        @(negedge clk);
        check("t4_start", 32'(start_TX), 32'd1);
        cnt = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            check("t4_no_done", 32'(req_done), 32'd0);
            if (timeout_err) begin
                cnt = c;
                break;
            end
        end
        check("t4_delay", 32'(cnt), 32'(ST + 1));
        @(negedge clk);
        check("t4_idle", 32'(busy), 32'd0);

        // Reset in the middle of a frame.
        do_reset();
        frame = 40;
        req_data[7:0] = 8'h11;
        req_valid = 3'b001;
        wait_ready(10, r);
        check("t5_ready", 32'(r), 32'd1);
        step();
        req_valid = '0;
        repeat (4) step();
        @(negedge clk);
        check("t5_in_frame", 32'(busy & tx_active), 32'd1);
        step();
        sync_reset = 1'b1;
        req_data[15:8] = 8'h22;
        req_valid = 3'b011;
        step();
        sync_reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("t5");
        check("t5_rr", 32'(req_ready), 32'd1);
        step();
        req_valid = '0;
        wait_idle("t5_idle");

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < N; i++) begin
            acc_cnt[i]  = 0;
            done_cnt[i] = 0;
            to_cnt[i]   = 0;
        end
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            r = req_ready;
            step();
            for (int i = 0; i < N; i++) begin
                if (r[i]) begin
                    req_valid[i] = ($urandom_range(0, 3) != 0);
                    req_data[8*i +: 8] = 8'($urandom);
                end else if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    req_valid[i] = 1'b1;
                    req_data[8*i +: 8] = 8'($urandom);
                end
            end
            tx_en = ($urandom_range(0, 15) != 0);
            frame = $urandom_range(1, 10);
        end
        req_valid = '0;
        tx_en = 1'b1;
        wait_idle("rnd_drain");
        total = 0;
        for (int i = 0; i < N; i++) begin
            check("rnd_accounting", 32'(done_cnt[i] + to_cnt[i]), 32'(acc_cnt[i]));
            total += done_cnt[i];
        end
        check("rnd_traffic", 32'(total > 50), 32'd1);

`ifdef UART_TX_ARB_LOCK_EN
        begin
            logic [N-1:0] seq [4];
            int n;
            mon_en = 1'b0;
            do_reset();
            frame = 3;
            req_lock = 3'b010;
            req_data[7:0]  = 8'hC0;
            req_data[15:8] = 8'hD1;
            req_valid = 3'b010;
            for (int k = 0; k < 4; k++)
                seq[k] = '0;
            n = 0;
            for (int c = 0; c < 400 && n < 4; c++) begin
                @(negedge clk);
                if (req_ready != 0) begin
                    seq[n] = req_ready;
                    n++;
                end
                step();
                if (n >= 1)
                    req_valid = 3'b011;
                if (n >= 3)
                    req_lock = '0;
            end
            check("lk_grant0", 32'(seq[0]), 32'd2);
            check("lk_grant1", 32'(seq[1]), 32'd2);
            check("lk_grant2", 32'(seq[2]), 32'd2);
            check("lk_release", 32'(seq[3]), 32'd1);
            req_valid = '0;
            wait_idle("lk_idle");
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
